// File: rtl/multi_reader_fifo.sv
// multi_reader_fifo
// ---------------------------------------------------------------------------
// Single-producer circular buffer with NumReaders independent consumers. Every
// pushed word is broadcast to all readers. A slot is reused only after the
// slowest reader has consumed it, because Full looks at the largest per-reader
// occupancy.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   Push, DataIn write request and write data
//   Pop          per-reader advance request, bit i = reader i
//   Flush        synchronous clear of pointers and sticky flags
//   DataOut      slice i = word at reader i's head (combinational, no latency)
//   Empty        bit i = reader i has nothing unread
//   Full         some reader holds BufferSize unread entries
//   AlmostFull   largest reader occupancy >= AlmostFullLevel
//   Count        slice i = reader i occupancy, 0..BufferSize
//   Ready        bit i*BufferSize+k = slot k holds an entry unread by reader i
//   Overflow     sticky: a push was attempted while Full
//   Underflow    sticky: a pop was attempted on an empty reader
//
// Handshake: Full acts as the inverse of write-ready and ~Empty[i] acts as
// read-valid for reader i. Both come from registered state only. A push is
// accepted when Push & ~Full & ~Flush. A pop on reader i is accepted when
// Pop[i] & ~Empty[i] & ~Flush. Requests that are refused change no pointer;
// outside Flush they set the matching sticky error flag.
// ---------------------------------------------------------------------------
module multi_reader_fifo #(
  parameter int DataWidth       = 32,
  parameter int BufferWidth     = 2,
  parameter int BufferSize      = 4,
  parameter int NumReaders      = 2,
  parameter int AlmostFullLevel = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Push,
  input  logic [DataWidth-1:0]                  DataIn,
  input  logic [NumReaders-1:0]                 Pop,
  input  logic                                  Flush,
  output logic [NumReaders*DataWidth-1:0]       DataOut,
  output logic [NumReaders-1:0]                 Empty,
  output logic                                  Full,
  output logic                                  AlmostFull,
  output logic [NumReaders*(BufferWidth+1)-1:0] Count,
  output logic [NumReaders*BufferSize-1:0]      Ready,
  output logic                                  Overflow,
  output logic                                  Underflow
);

  // Pointers carry one extra wrap bit. Write minus read is then the
  // occupancy for any state, including a completely full buffer.
  localparam int PtrWidth = BufferWidth + 1;

  logic [DataWidth-1:0]   mem    [BufferSize];
  logic [PtrWidth-1:0]    wr_ptr;
  logic [PtrWidth-1:0]    rd_ptr [NumReaders];
  logic [PtrWidth-1:0]    cnt    [NumReaders];
  logic [PtrWidth-1:0]    max_cnt;
  logic [BufferWidth-1:0] offset;
  logic                   push_ok;

  // Status decode; depends only on registered pointers and memory.
  always_comb begin
    cnt        = '{default: '0};
    max_cnt    = '0;
    offset     = '0;
    Full       = 1'b0;
    Empty      = '0;
    Count      = '0;
    Ready      = '0;
    DataOut    = '0;
    for (int i = 0; i < NumReaders; i++) begin
      cnt[i]   = wr_ptr - rd_ptr[i];
      Empty[i] = (cnt[i] == '0);
      if (cnt[i] == PtrWidth'(BufferSize)) Full = 1'b1;
      if (cnt[i] > max_cnt) max_cnt = cnt[i];
      Count[i*PtrWidth +: PtrWidth]     = cnt[i];
      DataOut[i*DataWidth +: DataWidth] = mem[rd_ptr[i][BufferWidth-1:0]];
      // Slot k is pending for reader i when its distance ahead of the head
      // (modulo depth) is smaller than that reader's occupancy.
      for (int k = 0; k < BufferSize; k++) begin
        offset = BufferWidth'(k) - rd_ptr[i][BufferWidth-1:0];
        Ready[i*BufferSize + k] = ({1'b0, offset} < cnt[i]);
      end
    end
    AlmostFull = (max_cnt >= PtrWidth'(AlmostFullLevel));
  end

  // A push is judged against Full as it stands at the start of the cycle.
  // A pop in the same cycle does not make room for it.
  assign push_ok = Push & ~Full & ~Flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      for (int i = 0; i < NumReaders; i++) rd_ptr[i] <= '0;
      for (int k = 0; k < BufferSize; k++) mem[k] <= '0;
    end else if (Flush) begin
      // Memory is left as is; only the pointers and flags are cleared.
      wr_ptr    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      for (int i = 0; i < NumReaders; i++) rd_ptr[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[BufferWidth-1:0]] <= DataIn;
        wr_ptr                       <= wr_ptr + PtrWidth'(1);
      end
      if (Push && Full) Overflow <= 1'b1;
      for (int i = 0; i < NumReaders; i++) begin
        if (Pop[i]) begin
          if (Empty[i]) Underflow <= 1'b1;
          else          rd_ptr[i] <= rd_ptr[i] + PtrWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_reader_fifo.sv
// Testbench for multi_reader_fifo.
// dut0 uses the default configuration: 2 readers, depth 4, AlmostFullLevel 3.
// dut1 uses 3 readers, depth 8, AlmostFullLevel 6, DataWidth 16.
module tb_multi_reader_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- dut0 ----------------
  logic        rst0, push0, flush0;
  logic [31:0] din0;
  logic [1:0]  pop0;
  logic [63:0] dout0;
  logic [1:0]  empty0;
  logic        full0, af0, ov0, un0;
  logic [5:0]  count0;
  logic [7:0]  ready0;

  multi_reader_fifo dut0 (
    .clk(clk), .rst(rst0), .Push(push0), .DataIn(din0), .Pop(pop0), .Flush(flush0),
    .DataOut(dout0), .Empty(empty0), .Full(full0), .AlmostFull(af0),
    .Count(count0), .Ready(ready0), .Overflow(ov0), .Underflow(un0)
  );

  // ---------------- dut1 ----------------
  logic        rst1, push1, flush1;
  logic [15:0] din1;
  logic [2:0]  pop1;
  logic [47:0] dout1;
  logic [2:0]  empty1;
  logic        full1, af1, ov1, un1;
  logic [11:0] count1;
  logic [23:0] ready1;

  multi_reader_fifo #(
    .DataWidth(16), .BufferWidth(3), .BufferSize(8), .NumReaders(3), .AlmostFullLevel(6)
  ) dut1 (
    .clk(clk), .rst(rst1), .Push(push1), .DataIn(din1), .Pop(pop1), .Flush(flush1),
    .DataOut(dout1), .Empty(empty1), .Full(full1), .AlmostFull(af1),
    .Count(count1), .Ready(ready1), .Overflow(ov1), .Underflow(un1)
  );

  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  // Inputs change 1 time unit after the rising edge. Outputs are sampled
  // at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    rst0 = 1'b1; push0 = 1'b0; flush0 = 1'b0; din0 = '0; pop0 = '0;
    rst1 = 1'b1; push1 = 1'b0; flush1 = 1'b0; din1 = '0; pop1 = '0;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    n_tests++; if (empty0 !== 2'b11) begin n_fail++; $display("FAIL reset_empty got=%b exp=%b", empty0, 2'b11); end
    n_tests++; if ({full0, af0, ov0, un0} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=%b", {full0, af0, ov0, un0}, 4'b0000); end
    n_tests++; if (count0 !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%h exp=%h", count0, 6'd0); end
    n_tests++; if (ready0 !== 8'h00) begin n_fail++; $display("FAIL reset_ready got=%h exp=%h", ready0, 8'h00); end
    n_tests++; if (dout0 !== 64'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=%h", dout0, 64'h0); end
    n_tests++; if (empty1 !== 3'b111) begin n_fail++; $display("FAIL reset_empty1 got=%b exp=%b", empty1, 3'b111); end
  endtask

  task automatic test_fill();
    for (int j = 0; j < 4; j++) begin
      push0 = 1'b1; din0 = 32'hA0 + 32'(j);
      tick();
      if (j == 0) begin
        n_tests++; if (count0 !== 6'b001_001) begin n_fail++; $display("FAIL fill_count1 got=%b exp=%b", count0, 6'b001_001); end
        n_tests++; if (dout0 !== {32'hA0, 32'hA0}) begin n_fail++; $display("FAIL fill_dout1 got=%h exp=%h", dout0, {32'hA0, 32'hA0}); end
        n_tests++; if (empty0 !== 2'b00) begin n_fail++; $display("FAIL fill_empty1 got=%b exp=%b", empty0, 2'b00); end
      end
      if (j == 2) begin
        n_tests++; if ({full0, af0} !== 2'b01) begin n_fail++; $display("FAIL fill_af3 got=%b exp=%b", {full0, af0}, 2'b01); end
      end
    end
    n_tests++; if (full0 !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=%b", full0, 1'b1); end
    n_tests++; if (count0 !== 6'b100_100) begin n_fail++; $display("FAIL fill_count4 got=%b exp=%b", count0, 6'b100_100); end
    n_tests++; if (ready0 !== 8'hFF) begin n_fail++; $display("FAIL fill_ready got=%h exp=%h", ready0, 8'hFF); end
    // A fifth push must be dropped and must not overwrite slot 0.
    din0 = 32'hA4;
    tick();
    push0 = 1'b0;
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", ov0, 1'b1); end
    n_tests++; if (count0 !== 6'b100_100) begin n_fail++; $display("FAIL ovf_count got=%b exp=%b", count0, 6'b100_100); end
    n_tests++; if (dout0[31:0] !== 32'hA0) begin n_fail++; $display("FAIL ovf_dout got=%h exp=%h", dout0[31:0], 32'hA0); end
  endtask

  task automatic test_independent_drain();
    for (int j = 0; j < 4; j++) begin
      n_tests++; if (dout0[31:0] !== 32'hA0 + 32'(j)) begin n_fail++; $display("FAIL drain_dout0 got=%h exp=%h", dout0[31:0], 32'hA0 + 32'(j)); end
      pop0 = 2'b01;
      tick();
      pop0 = 2'b00;
    end
    n_tests++; if (empty0 !== 2'b01) begin n_fail++; $display("FAIL drain_empty got=%b exp=%b", empty0, 2'b01); end
    n_tests++; if (full0 !== 1'b1) begin n_fail++; $display("FAIL drain_full got=%b exp=%b", full0, 1'b1); end
    n_tests++; if (count0 !== 6'b100_000) begin n_fail++; $display("FAIL drain_count got=%b exp=%b", count0, 6'b100_000); end
    n_tests++; if (un0 !== 1'b0) begin n_fail++; $display("FAIL drain_unf got=%b exp=%b", un0, 1'b0); end
    pop0 = 2'b10;
    tick();
    pop0 = 2'b00;
    n_tests++; if (full0 !== 1'b0) begin n_fail++; $display("FAIL r1pop_full got=%b exp=%b", full0, 1'b0); end
    n_tests++; if (ready0 !== 8'hE0) begin n_fail++; $display("FAIL r1pop_ready got=%h exp=%h", ready0, 8'hE0); end
    n_tests++; if (count0 !== 6'b011_000) begin n_fail++; $display("FAIL r1pop_count got=%b exp=%b", count0, 6'b011_000); end
    n_tests++; if (dout0[63:32] !== 32'hA1) begin n_fail++; $display("FAIL r1pop_dout got=%h exp=%h", dout0[63:32], 32'hA1); end
  endtask

  task automatic test_back_to_back();
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    n_tests++; if ({count0, ov0} !== 7'b0) begin n_fail++; $display("FAIL b2b_flush got=%b exp=%b", {count0, ov0}, 7'b0); end
    exp_q = {};
    for (int j = 0; j < 2; j++) begin
      push0 = 1'b1; din0 = 32'hB0 + 32'(j); exp_q.push_back(din0);
      tick();
    end
    push0 = 1'b0;
    n_tests++; if (count0 !== 6'b010_010) begin n_fail++; $display("FAIL b2b_start got=%b exp=%b", count0, 6'b010_010); end
    for (int j = 0; j < 10; j++) begin
      exp_word = exp_q.pop_front();
      n_tests++; if (dout0 !== {exp_word, exp_word}) begin n_fail++; $display("FAIL b2b_dout got=%h exp=%h", dout0, {exp_word, exp_word}); end
      push0 = 1'b1; din0 = 32'hC0 + 32'(j); pop0 = 2'b11; exp_q.push_back(din0);
      tick();
      n_tests++; if (count0 !== 6'b010_010) begin n_fail++; $display("FAIL b2b_count got=%b exp=%b", count0, 6'b010_010); end
    end
    push0 = 1'b0; pop0 = 2'b00;
    n_tests++; if ({ov0, un0} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags got=%b exp=%b", {ov0, un0}, 2'b00); end
    n_tests++; if (dout0[31:0] !== 32'hC8) begin n_fail++; $display("FAIL b2b_head got=%h exp=%h", dout0[31:0], 32'hC8); end
  endtask

  task automatic test_push_full_pop();
    for (int j = 0; j < 2; j++) begin
      push0 = 1'b1; din0 = 32'hD0 + 32'(j);
      tick();
    end
    n_tests++; if ({full0, count0} !== 7'b1_100_100) begin n_fail++; $display("FAIL pfp_pre got=%b exp=%b", {full0, count0}, 7'b1_100_100); end
    din0 = 32'hE0; pop0 = 2'b10;
    tick();
    push0 = 1'b0; pop0 = 2'b00;
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL pfp_ovf got=%b exp=%b", ov0, 1'b1); end
    n_tests++; if (count0 !== 6'b011_100) begin n_fail++; $display("FAIL pfp_count got=%b exp=%b", count0, 6'b011_100); end
    n_tests++; if (dout0 !== {32'hC9, 32'hC8}) begin n_fail++; $display("FAIL pfp_dout got=%h exp=%h", dout0, {32'hC9, 32'hC8}); end
  endtask

  task automatic test_pop_empty_push();
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    n_tests++; if ({empty0, ov0} !== 3'b110) begin n_fail++; $display("FAIL pep_flush got=%b exp=%b", {empty0, ov0}, 3'b110); end
    push0 = 1'b1; din0 = 32'hF0; pop0 = 2'b01;
    tick();
    push0 = 1'b0; pop0 = 2'b00;
    n_tests++; if (un0 !== 1'b1) begin n_fail++; $display("FAIL pep_unf got=%b exp=%b", un0, 1'b1); end
    n_tests++; if (count0 !== 6'b001_001) begin n_fail++; $display("FAIL pep_count got=%b exp=%b", count0, 6'b001_001); end
    n_tests++; if (dout0[31:0] !== 32'hF0) begin n_fail++; $display("FAIL pep_dout got=%h exp=%h", dout0[31:0], 32'hF0); end
    // Flush with push and pops asserted: the requests are ignored and the
    // flags are cleared.
    flush0 = 1'b1; push0 = 1'b1; din0 = 32'hF1; pop0 = 2'b11;
    tick();
    flush0 = 1'b0; push0 = 1'b0; pop0 = 2'b00;
    n_tests++; if (count0 !== 6'd0) begin n_fail++; $display("FAIL flush_count got=%b exp=%b", count0, 6'd0); end
    n_tests++; if (empty0 !== 2'b11) begin n_fail++; $display("FAIL flush_empty got=%b exp=%b", empty0, 2'b11); end
    n_tests++; if ({ov0, un0} !== 2'b00) begin n_fail++; $display("FAIL flush_flags got=%b exp=%b", {ov0, un0}, 2'b00); end
  endtask

  task automatic test_three_readers();
    for (int j = 0; j < 6; j++) begin
      push1 = 1'b1; din1 = 16'h1000 + 16'(j);
      tick();
      if (j == 4) begin
        n_tests++; if (af1 !== 1'b0) begin n_fail++; $display("FAIL r3_af5 got=%b exp=%b", af1, 1'b0); end
      end
    end
    push1 = 1'b0;
    n_tests++; if (af1 !== 1'b1) begin n_fail++; $display("FAIL r3_af6 got=%b exp=%b", af1, 1'b1); end
    n_tests++; if (count1 !== 12'h666) begin n_fail++; $display("FAIL r3_count6 got=%h exp=%h", count1, 12'h666); end
    n_tests++; if (ready1 !== 24'h3F3F3F) begin n_fail++; $display("FAIL r3_ready6 got=%h exp=%h", ready1, 24'h3F3F3F); end
    n_tests++; if (full1 !== 1'b0) begin n_fail++; $display("FAIL r3_full got=%b exp=%b", full1, 1'b0); end
    pop1 = 3'b111;
    tick();
    pop1 = 3'b000;
    n_tests++; if (af1 !== 1'b0) begin n_fail++; $display("FAIL r3_af_pop got=%b exp=%b", af1, 1'b0); end
    n_tests++; if (count1 !== 12'h555) begin n_fail++; $display("FAIL r3_count5 got=%h exp=%h", count1, 12'h555); end
    n_tests++; if (ready1 !== 24'h3E3E3E) begin n_fail++; $display("FAIL r3_ready5 got=%h exp=%h", ready1, 24'h3E3E3E); end
    n_tests++; if (dout1 !== {3{16'h1001}}) begin n_fail++; $display("FAIL r3_dout got=%h exp=%h", dout1, {3{16'h1001}}); end
  endtask

  task automatic test_reset_mid();
    push1 = 1'b1; din1 = 16'h2000;
    tick();
    push1 = 1'b0;
    #2;
    rst1 = 1'b1;
    #1;
    // Reset is asynchronous: outputs must be back at reset values before
    // any further clock edge.
    n_tests++; if (empty1 !== 3'b111) begin n_fail++; $display("FAIL rmid_empty got=%b exp=%b", empty1, 3'b111); end
    n_tests++; if (count1 !== 12'h000) begin n_fail++; $display("FAIL rmid_count got=%h exp=%h", count1, 12'h000); end
    n_tests++; if (ready1 !== 24'h0) begin n_fail++; $display("FAIL rmid_ready got=%h exp=%h", ready1, 24'h0); end
    n_tests++; if (dout1 !== 48'h0) begin n_fail++; $display("FAIL rmid_dout got=%h exp=%h", dout1, 48'h0); end
    n_tests++; if ({full1, af1, ov1, un1} !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags got=%b exp=%b", {full1, af1, ov1, un1}, 4'b0000); end
    tick();
    rst1 = 1'b0;
    tick();
    n_tests++; if ({empty1, count1} !== {3'b111, 12'h000}) begin n_fail++; $display("FAIL rmid_after got=%h exp=%h", {empty1, count1}, {3'b111, 12'h000}); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_fill();
    test_independent_drain();
    test_back_to_back();
    test_push_full_pop();
    test_pop_empty_push();
    test_three_readers();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_reader_fifo.md
# multi_reader_fifo

Parametrised successor of the two-reader weight/input FIFO in the MAC datapath. One producer writes a circular buffer; `NumReaders` consumers each keep an independent read pointer, so the same weight or activation word can be broadcast to several MAC lanes that drain at different rates. A slot is reused only after every reader has consumed it. The block adds per-reader occupancy counts, almost-full, synchronous flush and sticky overflow/underflow flags, and works for any power-of-two depth.

## Interface
Parameters:
- `DataWidth`, 32, word width
- `BufferWidth`, 2, address width; depth = 2**BufferWidth
- `BufferSize`, 4, depth; must equal 2**BufferWidth
- `NumReaders`, 2, number of independent read ports, 1..8
- `AlmostFullLevel`, 3, AlmostFull asserts when worst-case occupancy ≥ this value (1..BufferSize)

Ports (clock is `clk`; reset is `rst`, asynchronous, active-high):
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous active-high reset
- `Push` in 1: write `DataIn` at tail
- `DataIn` in DataWidth: write data
- `Pop` in NumReaders: bit i advances reader i's head
- `Flush` in 1: synchronous clear of all pointers and flags
- `DataOut` out NumReaders*DataWidth: slice i = entry at reader i's head
- `Empty` out NumReaders: bit i = reader i has no unread entry
- `Full` out 1: some reader has BufferSize unread entries
- `AlmostFull` out 1: max reader occupancy ≥ AlmostFullLevel
- `Count` out NumReaders*(BufferWidth+1): slice i = reader i occupancy, 0..BufferSize
- `Ready` out NumReaders*BufferSize: bit i*BufferSize+k = slot k holds an entry unread by reader i
- `Overflow` out 1: sticky, push attempted while Full
- `Underflow` out 1: sticky, pop attempted on an empty reader

## Operation
- Write pointer W and read pointers R_i are BufferWidth+1 bits; the MSB is the wrap bit and replaces the old per-reader round logic. Address = low BufferWidth bits.
- Count_i = (W − R_i) mod 2**(BufferWidth+1). Empty_i = (Count_i == 0). Full = any Count_i == BufferSize.
- Ready bit for slot k, reader i: set iff offset (k − R_i[BW-1:0]) mod BufferSize < Count_i.
- Accepted push: `Push` & ~Full & ~Flush → mem[W] ← DataIn, W ← W+1. Push while Full: dropped, W unchanged, Overflow ← 1.
- Accepted pop_i: `Pop[i]` & ~Empty_i & ~Flush → R_i ← R_i+1. Pop on empty reader: ignored, Underflow ← 1.
- Full and Empty are evaluated from state at the start of the cycle. A push while Full is dropped even if the slowest reader pops in the same cycle. A pop on an empty reader is ignored even if a push happens in the same cycle.
- Readers are fully independent. Any subset may pop in the same cycle as a push.
- Flush: W, all R_i, Overflow and Underflow ← 0 at the next edge. Push and Pop in that cycle are ignored and do not set flags. Memory contents are not cleared.
- DataOut slice i = mem[R_i] combinationally (no read latency). When Empty_i is set the value is stale and must be ignored.
- Overflow and Underflow are cleared only by `rst` or `Flush`.

## Timing
- Reset (async, immediate): W = R_i = 0, memory = 0. Outputs: Empty all 1, Full 0, AlmostFull 0, Count all 0, Ready all 0, Overflow 0, Underflow 0, DataOut all 0.
- Reset asserted mid-operation discards all contents and behaves identically.
- Write-to-visible latency is 1 cycle: data pushed at edge t appears on DataOut, Empty_i falls, and Count_i increments after edge t.
- Pop takes effect at the edge. The next head word is on DataOut in the following cycle.
- Pointer wrap from 2**(BW+1)−1 to 0 is natural modulo arithmetic with no special case.
- All status outputs are combinational from registered pointers (no input-to-output paths except through registers).

## Test plan
- Reset, push 0xA0..0xA3 (depth 4) → Full=1 after the 4th edge, Count=4/4, Ready=4'hF/4'hF. Then a 5th push 0xA4 → dropped, Overflow=1, Count stays 4.
- Reader 0 pops 4 times, reader 1 idle → DataOut0 sequence A0,A1,A2,A3, Empty0=1, Full stays 1 (Count1=4). Reader 1 pops once → Full=0, Ready1=4'hE.
- Simultaneous push and pop on both readers for 10 cycles, starting at Count=2 → Count constant at 2, data in order across two pointer wraps, no flags.
- Push while Full and reader 1 pops in the same cycle → push dropped, Overflow=1, Count1 becomes 3.
- Pop on empty reader with a push in the same cycle → pop ignored, Underflow=1, Count becomes 1. Flush next cycle → all Counts 0, Empty all 1, Overflow=0, Underflow=0.
- NumReaders=3, BufferWidth=3, AlmostFullLevel=6: push 6 → AlmostFull=1. Pop one word from every reader → AlmostFull=0. Assert rst mid-stream → all outputs return to reset values immediately.
